dffrl_s: RTL and testbench
==========================

Name: dffrl_s

Overview:
- Parameterized-width D flip-flop bank with synchronous active-low reset and mux-scan support.
- Generic storage primitive used throughout the core, e.g. the 5-bit thread-state register of the IFU thread FSM, which connects din/q and leaves so/si unconnected.
- Reset has priority over scan; scan has priority over functional data.

Parameters:
- SIZE, 1, bit width of din, si, q and so (legal range 1 to 1024).

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst_l  input  1  synchronous reset, active-low; sampled only on the rising edge of clk.
- din  input  SIZE  functional data input.
- se  input  1  scan enable; 1 selects si instead of din.
- si  input  SIZE  scan data input (parallel scan, one bit per flop).
- q  output  SIZE  registered output.
- so  output  SIZE  scan output; identical to q, combinational wire.

Behaviour:
- All state updates occur on the rising edge of clk. No asynchronous paths.
- Next-state priority at each rising edge:
  - rst_l==0: q <= all zeros.
  - else se==1: q <= si.
  - else: q <= din.
- Reset value: q = {SIZE{1'b0}} and so = {SIZE{1'b0}} after any edge with rst_l low. This is the only defined reset value; no parameter overrides it.
- Reset is synchronous:
  - rst_l falling between edges does not change q until the next rising edge.
  - rst_l rising mid-cycle takes effect at the next edge, which loads din or si per se.
- Latency: 1 cycle from din/si to q. so tracks q with zero added latency.
- se and rst_l both asserted: reset wins, q=0.
- se toggling mid-operation: the value sampled at the edge selects the source. No glitch on q between edges.
- Power-up, before the first reset edge: q is X in simulation. The design does not rely on any initial value.
- Unknown inputs:
  - X/Z on rst_l propagates X into q; no masking.
  - si unconnected with se=0 must not affect q.
- Width: every bit is independent. din, si and q bit i map to q/so bit i. No width extension or truncation.
- so is not a shift chain. Serial scan stitching is done by the instantiator.
- Simulation-only checks are allowed and must be excluded from synthesis:
  - flag se==1 while rst_l==1 if a scan-check define is set;
  - flag SIZE < 1 at elaboration.
- Hold behaviour does not exist: with rst_l=1 and se=0, q follows din every cycle. Callers implement hold by feeding q back to din.

Test Plan:
- SIZE=5, rst_l=0 for 1 edge with din=5'b11001 -> q=5'b00000, so=5'b00000 after that edge; q unchanged before the edge.
- SIZE=5, rst_l=1, se=0, din sequence 5'b00001, 5'b11001, 5'b00101, 5'b10011 on successive edges -> q equals each value exactly one cycle later.
- SIZE=5, rst_l=1, se=1, si=5'b10101, din=5'b01010 -> q=5'b10101 after the edge. Then se=0 -> q=5'b01010 after the next edge.
- SIZE=5, rst_l=0 and se=1 together with si=5'b11111 -> q=5'b00000 (reset priority).
- Synchronous check:
  - q=5'b00111, rst_l pulsed low strictly between edges and high again before the edge -> q stays 5'b00111.
  - rst_l low across the edge -> q=0 only after that edge.
- SIZE=1 and SIZE=64, random din/si/se/rst_l for 1000 cycles -> q matches a reference model every cycle, and so==q at all times.

Source files
------------

// File: rtl/dffrl_s.sv
// dffrl_s: SIZE-bit D flip-flop bank with synchronous active-low reset and
// parallel mux-scan. Reset beats scan, scan beats functional data. so is a
// plain copy of q; serial scan stitching is left to the instantiator.
module dffrl_s #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [SIZE-1:0] din,
  input  logic            se,
  input  logic [SIZE-1:0] si,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] so
);

  logic [SIZE-1:0] src_p0;
  logic [SIZE-1:0] q_p1;

  // Source select: scan data when se is high, functional data otherwise.
  always_comb begin
    src_p0 = din;
    if (se) src_p0 = si;
  end

  // ---- stage p0 -> p1 boundary: the storage flops ----
  // Synchronous reset. The ternary keeps an unknown rst_l visible as X in
  // simulation instead of silently choosing one branch.
  always_ff @(posedge clk) begin
    q_p1 <= rst_l ? src_p0 : {SIZE{1'b0}};
  end

  assign q  = q_p1;
  assign so = q_p1;

`ifndef SYNTHESIS
  // Reject a zero-width (or negative) bank at elaboration.
  if (SIZE < 1) begin : g_size_chk
    $error("dffrl_s: SIZE must be at least 1");
  end

`ifdef DFFRL_SCAN_CHECK
  // Scan enabled outside reset is suspicious in functional runs.
  a_scan_outside_reset : assert property (@(posedge clk) !(rst_l && se));
`endif
`endif

endmodule

// File: tb/tb_dffrl_s.sv
// Bench for dffrl_s: directed SIZE=5 cases plus randomized SIZE=1 and
// SIZE=64 traffic, with expected values queued on drive and popped after
// the edge that produces them.
module tb_dffrl_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT with SIZE=5
  logic       rst_l5 = 1'b1, se5 = 1'b0;
  logic [4:0] din5 = '0, si5 = '0, q5, so5;
  // DUT with SIZE=1
  logic       rst_l1 = 1'b1, se1 = 1'b0;
  logic [0:0] din1 = '0, si1 = '0, q1, so1;
  // DUT with SIZE=64
  logic        rst_l64 = 1'b1, se64 = 1'b0;
  logic [63:0] din64 = '0, si64 = '0, q64, so64;

  logic [4:0]  exp5_q[$];
  logic [0:0]  exp1_q[$];
  logic [63:0] exp64_q[$];

  dffrl_s #(.SIZE(5)) u_dut5 (
    .clk(clk), .rst_l(rst_l5), .din(din5), .se(se5), .si(si5), .q(q5), .so(so5)
  );
  dffrl_s #(.SIZE(1)) u_dut1 (
    .clk(clk), .rst_l(rst_l1), .din(din1), .se(se1), .si(si1), .q(q1), .so(so1)
  );
  dffrl_s #(.SIZE(64)) u_dut64 (
    .clk(clk), .rst_l(rst_l64), .din(din64), .se(se64), .si(si64), .q(q64), .so(so64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one flop bank at a rising edge.
  function automatic logic [63:0] ref_next(input logic r, input logic s,
                                           input logic [63:0] d, input logic [63:0] sc);
    if (!r)     return 64'd0;
    else if (s) return sc;
    else        return d;
  endfunction

  // Drive the SIZE=5 bank at the falling edge, queue its expectation,
  // then compare one time unit after the following rising edge.
  task automatic step5(input string tag, input logic r, input logic s,
                       input logic [4:0] d, input logic [4:0] sc);
    logic [63:0] e;
    logic [4:0]  e5;
    @(negedge clk);
    rst_l5 = r; se5 = s; din5 = d; si5 = sc;
    e = ref_next(r, s, {59'd0, d}, {59'd0, sc});
    exp5_q.push_back(e[4:0]);
    @(posedge clk); #1;
    e5 = exp5_q.pop_front();
    chk({tag, ".q"},  {59'd0, q5},  {59'd0, e5});
    chk({tag, ".so"}, {59'd0, so5}, {59'd0, e5});
  endtask

  initial begin
    logic [4:0] seq [4];
    seq[0] = 5'b00001; seq[1] = 5'b11001; seq[2] = 5'b00101; seq[3] = 5'b10011;

    // Reset with functional data present: q must clear.
    step5("rst", 1'b0, 1'b0, 5'b11001, 5'b00000);

    // Functional load sequence, one cycle latency each.
    for (int i = 0; i < 4; i++) step5($sformatf("load%0d", i), 1'b1, 1'b0, seq[i], ~seq[i]);

    // Reset applied: q unchanged before the edge, zero after it.
    @(negedge clk);
    rst_l5 = 1'b0; din5 = 5'b11001;
    #2 chk("rst_pre_edge", {59'd0, q5}, {59'd0, 5'b10011});
    step5("rst_post_edge", 1'b0, 1'b0, 5'b11001, 5'b00000);

    // Scan select, then back to functional.
    step5("scan", 1'b1, 1'b1, 5'b01010, 5'b10101);
    step5("func", 1'b1, 1'b0, 5'b01010, 5'b10101);

    // Reset beats scan.
    step5("rst_vs_scan", 1'b0, 1'b1, 5'b01010, 5'b11111);

    // Load 00111, then pulse rst_l low strictly between edges.
    step5("load7", 1'b1, 1'b0, 5'b00111, 5'b00000);
    @(negedge clk);
    rst_l5 = 1'b0;
    #1 rst_l5 = 1'b1;
    #1 chk("glitch_mid", {59'd0, q5}, {59'd0, 5'b00111});
    @(posedge clk); #1;
    chk("glitch_edge", {59'd0, q5}, {59'd0, 5'b00111});
    // rst_l low across the edge clears only at that edge.
    step5("rst_across", 1'b0, 1'b0, 5'b00111, 5'b00000);
    step5("rst_release", 1'b1, 1'b0, 5'b10110, 5'b01001);

    // Randomized SIZE=1 and SIZE=64 traffic, reset in about 1 of 16 cycles.
    for (int c = 0; c < 1000; c++) begin
      logic [63:0] e;
      logic [63:0] got1;
      @(negedge clk);
      rst_l1  = ($urandom_range(15) != 0);
      se1     = $urandom_range(1);
      din1    = 1'($urandom);
      si1     = 1'($urandom);
      rst_l64 = ($urandom_range(15) != 0);
      se64    = $urandom_range(1);
      din64   = {$urandom, $urandom};
      si64    = {$urandom, $urandom};
      e = ref_next(rst_l1, se1, {63'd0, din1}, {63'd0, si1});
      exp1_q.push_back(e[0:0]);
      exp64_q.push_back(ref_next(rst_l64, se64, din64, si64));
      @(posedge clk); #1;
      got1 = {63'd0, q1};
      chk($sformatf("w1_c%0d", c), got1, {63'd0, exp1_q.pop_front()});
      chk($sformatf("w1_so_c%0d", c), {63'd0, so1}, got1);
      e = exp64_q.pop_front();
      chk($sformatf("w64_c%0d", c), q64, e);
      chk($sformatf("w64_so_c%0d", c), so64, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
